axi_req_master: RTL

AXI_REQ_MASTER -- requirements
Module: axi_req_master

---
 rtl/axi_req_master_if.sv | 89 ++++++++
 rtl/axi_req_master.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/axi_req_master_if.sv
// AXI4 bus bundle shared by initiator and target sides.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_req_master.sv
// Core request/grant port to AXI4 initiator bridge: one single-beat
// transaction in flight, response delivered as a one-cycle rvalid_o pulse.
module axi_req_master #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  AXI_BUS.Master                      AXI_Master
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [2:0]  AXSIZE = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STRB_W-1:0]         be_q, be_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic aw_valid, w_valid, aw_hs, w_hs;

  // Each write channel stays valid until its own handshake has been recorded.
  assign aw_valid = (state_q == WRITE) && !aw_done_q;
  assign w_valid  = (state_q == WRITE) && !w_done_q;
  assign aw_hs    = aw_valid && AXI_Master.aw_ready;
  assign w_hs     = w_valid && AXI_Master.w_ready;

  assign AXI_Master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign AXI_Master.aw_addr   = addr_q;
  assign AXI_Master.aw_len    = '0;
  assign AXI_Master.aw_size   = AXSIZE;
  assign AXI_Master.aw_burst  = 2'b01;
  assign AXI_Master.aw_lock   = 1'b0;
  assign AXI_Master.aw_cache  = '0;
  assign AXI_Master.aw_prot   = '0;
  assign AXI_Master.aw_qos    = '0;
  assign AXI_Master.aw_region = '0;
  assign AXI_Master.aw_atop   = '0;
  assign AXI_Master.aw_user   = '0;
  assign AXI_Master.aw_valid  = aw_valid;

  assign AXI_Master.w_data    = wdata_q;
  assign AXI_Master.w_strb    = be_q;
  assign AXI_Master.w_last    = 1'b1;
  assign AXI_Master.w_user    = '0;
  assign AXI_Master.w_valid   = w_valid;

  assign AXI_Master.b_ready   = (state_q == WRESP);

  assign AXI_Master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign AXI_Master.ar_addr   = addr_q;
  assign AXI_Master.ar_len    = '0;
  assign AXI_Master.ar_size   = AXSIZE;
  assign AXI_Master.ar_burst  = 2'b01;
  assign AXI_Master.ar_lock   = 1'b0;
  assign AXI_Master.ar_cache  = '0;
  assign AXI_Master.ar_prot   = '0;
  assign AXI_Master.ar_qos    = '0;
  assign AXI_Master.ar_region = '0;
  assign AXI_Master.ar_user   = '0;
  assign AXI_Master.ar_valid  = (state_q == READ);

  assign AXI_Master.r_ready   = (state_q == RDATA);

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // Next-state, grant and response capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    gnt_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i && rst_ni) begin
          gnt_o   = 1'b1;
          addr_d  = addr_i;
          be_d    = be_i;
          wdata_d = wdata_i;
          state_d = we_i ? WRITE : READ;
        end
      end
      WRITE: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        // Both in one cycle go straight on; otherwise wait for both flags.
        if ((aw_hs && w_hs) || (aw_done_q && w_done_q)) begin
          state_d   = WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRESP: begin
        if (AXI_Master.b_valid) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          err_d    = AXI_Master.b_resp[1];
        end
      end
      READ: begin
        if (AXI_Master.ar_ready) state_d = RDATA;
      end
      RDATA: begin
        if (AXI_Master.r_valid) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = AXI_Master.r_data;
          err_d    = AXI_Master.r_resp[1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered payload/response, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule
